// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the MEM stage (port 0)
// and the loader/debug port (port 1). Each access takes IDLE -> ACCESS -> DONE.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  output logic        stall0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic        last_grant;
  logic        gnt_l, we_l, err_l;
  logic [31:0] addr_l, wdata_l;

  logic        grant_vld, grant_port;
  logic        sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] rd_val;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    grant_vld  = req0 | req1;
    grant_port = (req0 & req1) ? ~last_grant : req1;
    sel_we     = grant_port ? we1    : we0;
    sel_addr   = grant_port ? addr1  : addr0;
    sel_wdata  = grant_port ? wdata1 : wdata0;
    sel_err    = ((sel_addr % 32'(WORD_BYTES)) != 32'd0) || (sel_addr >= 32'(ADDR_LIMIT));
    rd_val     = (we_l | err_l) ? 32'd0 : mem_rdata;
  end

  // rst gates the enables so a reset landing in ACCESS never commits a write.
  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_addr  = addr_l;
        mem_wdata = wdata_l;
        mem_we    = we_l & ~err_l & ~rst;
        mem_re    = ~we_l & ~err_l & ~rst;
        state_nx  = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_l      <= 1'b0;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      addr_l     <= 32'd0;
      wdata_l    <= 32'd0;
      ack0       <= 1'b0;
      err0       <= 1'b0;
      rdata0     <= 32'd0;
      ack1       <= 1'b0;
      err1       <= 1'b0;
      rdata1     <= 32'd0;
    end else begin
      state  <= state_nx;
      ack0   <= 1'b0;
      err0   <= 1'b0;
      rdata0 <= 32'd0;
      ack1   <= 1'b0;
      err1   <= 1'b0;
      rdata1 <= 32'd0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            gnt_l      <= grant_port;
            last_grant <= grant_port;
            we_l       <= sel_we;
            addr_l     <= sel_addr;
            wdata_l    <= sel_wdata;
            err_l      <= sel_err;
          end
        end
        ACCESS: begin
          // Completion registers are loaded here so they are visible exactly in DONE.
          ack0   <= ~gnt_l;
          err0   <= ~gnt_l & err_l;
          rdata0 <= gnt_l ? 32'd0 : rd_val;
          ack1   <= gnt_l;
          err1   <= gnt_l & err_l;
          rdata1 <= gnt_l ? rd_val : 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign stall0 = req0 & ~ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_LIMIT = 1024;
  localparam int unsigned WORD_BYTES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, stall0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .WORD_BYTES(WORD_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight, phase 0 free, 1 access, 2 done.
  logic [31:0] ref_mem [0:255];
  int          phase = 0;
  bit          m_port, m_we, m_err;
  bit          m_last = 1'b1;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          chk_on = 1'b0;
  bit          saw0, saw1;
  logic [31:0] got_rd;
  logic        got_err;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  function automatic bit bad_addr(logic [31:0] a);
    return ((a % WORD_BYTES) != 0) || (a >= ADDR_LIMIT);
  endfunction

  task automatic step();
    bit d0, d1;
    @(negedge clk);
    d0 = (phase == 2) && !m_port;
    d1 = (phase == 2) && m_port;
    saw0 = ack0; saw1 = ack1;
    got_rd = m_port ? rdata1 : rdata0;
    got_err = m_port ? err1 : err0;
    if (chk_on) begin
      chk("ack0", 32'(ack0), 32'(d0));
      chk("ack1", 32'(ack1), 32'(d1));
      chk("err0", 32'(err0), 32'(d0 && m_err));
      chk("err1", 32'(err1), 32'(d1 && m_err));
      chk("rdata0", rdata0, d0 ? m_rdata : 32'd0);
      chk("rdata1", rdata1, d1 ? m_rdata : 32'd0);
      chk("stall0", 32'(stall0), 32'(req0 && !d0));
      chk("mem_we", 32'(mem_we), 32'(phase == 1 && m_we && !m_err && !rst));
      chk("mem_re", 32'(mem_re), 32'(phase == 1 && !m_we && !m_err && !rst));
      if (phase == 1) chk("mem_addr", mem_addr, m_addr);
      if (phase == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (rst) begin
      phase = 0;
      m_last = 1'b1;
    end else begin
      case (phase)
        0: if (req0 || req1) begin
          m_port  = (req0 && req1) ? !m_last : req1;
          m_last  = m_port;
          m_we    = m_port ? we1 : we0;
          m_addr  = m_port ? addr1 : addr0;
          m_wdata = m_port ? wdata1 : wdata0;
          m_err   = bad_addr(m_addr);
          m_rdata = (m_we || m_err) ? 32'd0 : ref_mem[m_addr / WORD_BYTES];
          phase   = 1;
        end
        1: begin
          if (m_we && !m_err) ref_mem[m_addr / WORD_BYTES] = m_wdata;
          phase = 2;
        end
        default: phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one request on a port until it is acked (bounded), then release it.
  task automatic xfer(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      done = p ? saw1 : saw0;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    if (p) req1 = 0; else req0 = 0;
  endtask

  task automatic rand_fields(output logic we, output logic [31:0] a, output logic [31:0] d);
    int r = $urandom_range(0, 9);
    we = $urandom_range(0, 1);
    d  = $urandom;
    if (r <= 6)      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (r == 7) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (r == 8) a = 32'(ADDR_LIMIT) + ($urandom & 32'h0FFF_FFFF);
    else             a = ($urandom_range(0, 1) != 0) ? 32'(ADDR_LIMIT) : 32'hFFFF_FFFC;
  endtask

  initial begin
    int a0, a1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    rst = 1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
    chk("rst_stall0", 32'(stall0), 32'd0);
    rst = 0;
    chk_on = 1;

    // Simultaneous requests straight after reset: port 0 first.
    req0 = 1; we0 = 0; addr0 = 32'h20; wdata0 = 0;
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    a0 = -1; a1 = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (saw0 && a0 < 0) begin a0 = i; chk("sim_rd_old", got_rd, init_word(8)); req0 = 0; end
      if (saw1 && a1 < 0) begin a1 = i; req1 = 0; end
    end
    chk("sim_ack0_cyc", 32'(a0), 32'd2);
    chk("sim_ack1_cyc", 32'(a1), 32'd5);
    xfer(0, 0, 32'h20, 0);
    chk("sim_rd_new", got_rd, 32'h1234_5678);

    // Write then read through port 0.
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF);
    xfer(0, 0, 32'h10, 0);
    chk("wr_rd_data", got_rd, 32'hDEAD_BEEF);
    chk("wr_rd_err", 32'(got_err), 32'd0);

    // Errors: misaligned read, out-of-range write.
    xfer(0, 0, 32'h13, 0);
    chk("mis_err", 32'(got_err), 32'd1);
    chk("mis_rdata", got_rd, 32'd0);
    xfer(1, 1, 32'h400, 32'hFFFF_FFFF);
    chk("oor_err", 32'(got_err), 32'd1);

    // Reset during the ACCESS cycle of a write.
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hAAAA_5555;
    step();
    rst = 1;
    step();
    rst = 0; req0 = 0;
    step();
    step();
    chk("rst_mid_mem", mem[12], init_word(12));

    // Request fields change after grant.
    req0 = 1; we0 = 0; addr0 = 32'h40;
    step();
    addr0 = 32'h44;
    for (int i = 0; i < 4; i++) step();
    req0 = 0;
    step();

    // Fairness: both hold requests for 12 cycles.
    req0 = 1; we0 = 0; addr0 = 32'h50;
    req1 = 1; we1 = 0; addr1 = 32'h54;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      a0 += int'(saw0);
      a1 += int'(saw1);
    end
    chk("fair_ack0", 32'(a0), 32'd2);
    chk("fair_ack1", 32'(a1), 32'd2);
    req0 = 0; req1 = 0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if (req0 && saw0) req0 = 0;
      if (req1 && saw1) req1 = 0;
      if (!req0) begin
        if ($urandom_range(0, 1) != 0) begin req0 = 1; rand_fields(we0, addr0, wdata0); end
      end else if ($urandom_range(0, 7) == 0) rand_fields(we0, addr0, wdata0);
      else if ($urandom_range(0, 31) == 0) req0 = 0;
      if (!req1) begin
        if ($urandom_range(0, 1) != 0) begin req1 = 1; rand_fields(we1, addr1, wdata1); end
      end else if ($urandom_range(0, 7) == 0) rand_fields(we1, addr1, wdata1);
      else if ($urandom_range(0, 31) == 0) req1 = 0;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Controller that shares the single-ported data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: program/data loader or debug port.
- Arbitrates with round-robin, latches the winning request and sequences one memory access.
- Returns read data and an ack, and produces the pipeline stall.
- Sits between the MEM stage/loader and the data memory; it drives the memory's writeEn, readEn, address and WriteData, and samples ReadData.

Parameters:
- ADDR_LIMIT, 1024: first byte address outside the memory. Any address at or above it is an error.
- WORD_BYTES, 4: bytes per word. Addresses must be multiples of this value.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req0  input  1  port 0 request, level; held until ack0
- we0  input  1  port 0 write (1) / read (0)
- addr0  input  32  port 0 byte address
- wdata0  input  32  port 0 write data
- ack0  output  1  port 0 completion pulse, 1 cycle
- err0  output  1  port 0 error, valid with ack0
- rdata0  output  32  port 0 read data, valid with ack0 when we0=0
- stall0  output  1  pipeline stall = req0 & ~ack0
- req1, we1, addr1, wdata1, ack1, err1, rdata1: port 1 equivalents (no stall output)
- mem_we  output  1  to data memory writeEn
- mem_re  output  1  to data memory readEn
- mem_addr  output  32  to data memory address
- mem_wdata  output  32  to data memory WriteData
- mem_rdata  input  32  from data memory ReadData (combinational read)

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE; all memory controls 0.
- IDLE, one request present: grant it.
- IDLE, both requests present: grant the port != last_grant; then last_grant <= granted port.
- On grant, latch gnt, we, addr, wdata into internal registers.
- Error check at grant: err_l set if addr % WORD_BYTES != 0 or addr >= ADDR_LIMIT. Next state is ACCESS.
- ACCESS (1 cycle): mem_addr=addr_l, mem_wdata=wdata_l.
  - mem_we = we_l & ~err_l.
  - mem_re = ~we_l & ~err_l.
  - The memory write commits on the ACCESS→DONE edge.
  - rdata_l <= (we_l|err_l) ? 0 : mem_rdata.
  - Next state is DONE.
- DONE (1 cycle): ack of the granted port = 1; err = err_l; rdata = rdata_l; memory controls 0. Next state is IDLE.
- Latency: request sampled in IDLE at edge N, ack high in cycle N+2. Throughput is one access per 3 cycles.
- ack, err and rdata are registered and asserted only in DONE.
  - rdata of the non-granted port stays 0.
  - rdata of the granted port reads 0 outside DONE.
- stall0 is combinational. It is high on every cycle req0=1 except the DONE cycle that acks port 0.
- Requests are sampled only in IDLE. A request arriving during ACCESS/DONE waits.
- Requester fields may change after grant without effect; latched values are used.
- Request withdrawn after grant: the transaction still completes and ack pulses.
- Back-to-back requests with both ports always requesting: grants alternate 0,1,0,1. No starvation.
- An errored access issues no memory enable and does not modify memory.
- Reset in any state: next cycle is IDLE, acks 0, no write issued, even if rst is asserted during ACCESS. A pending latched request is dropped; the requester re-requests.
- Address arithmetic is unsigned 32-bit. The ADDR_LIMIT comparison is unsigned.

Test Plan:
- Write via port 0, then read: req0,we0=1,addr0=0x10,wdata0=0xDEADBEEF → mem_we=1 in ACCESS, ack0 at N+2. Then read addr0=0x10 → rdata0=0xDEADBEEF, err0=0.
- Simultaneous requests after reset: req0 (read 0x20) and req1 (write 0x20=0x12345678) together → port 0 granted first, rdata0=old value, ack0 at N+2. Port 1 acks at N+5; a subsequent read of 0x20 returns 0x12345678.
- Fairness: both ports hold req continuously for 12 cycles → ack0/ack1 alternate, 4 acks total (2 each). stall0 high except in ack0 cycles.
- Errors: addr0=0x13 (misaligned) → ack0=1, err0=1, rdata0=0, mem_we/mem_re never asserted. addr1=0x400 with we1=1 → err1=1, memory unchanged.
- Reset mid-operation: assert rst in the ACCESS cycle of a write to 0x30=0xAAAA5555 → no ack, state IDLE, mem_we low after reset, location 0x30 not written.
- Request changes after grant: change addr0 from 0x40 to 0x44 the cycle after grant → access uses 0x40.
